fir_serial_mac: RTL and testbench

Parametrised, time-multiplexed FIR filter: one multiplier-accumulator shared across all taps, one tap per clock. Coefficients are runtime-loadable and the sample path uses valid/ready handshakes on both input and output. It replaces the fixed 15-tap, fully-parallel FIR in the signal path wherever the sample rate is at most clk/(TAPS+2) and multiplier area matters.

---
 rtl/fir_serial_mac_if.sv | 30 +++
 rtl/fir_serial_mac.sv | 100 ++++++++++
 tb/tb_fir_serial_mac.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_serial_mac_if.sv
// Sample-stream handshake and coefficient-write bundle for fir_serial_mac.
interface fir_serial_mac_if #(
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int TAPS = 15
);
  localparam int AW = DW + CW + $clog2(TAPS);
  localparam int KW = $clog2(TAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic                 coef_we;
  logic [KW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_err;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, coef_err
  );
endinterface

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one shared multiply-accumulate, one tap per clock,
// runtime-loadable coefficients, valid/ready on both sample ports.
module fir_serial_mac #(
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int TAPS = 15
) (
  input  logic            clk,
  input  logic            nreset,
  fir_serial_mac_if.slave bus
);
  localparam int AW = DW + CW + $clog2(TAPS);
  localparam int KW = $clog2(TAPS);
  localparam logic [KW:0]   TAPS_K = (KW+1)'(TAPS);
  localparam logic [KW-1:0] LAST_K = KW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [DW-1:0]    d [TAPS];
  logic signed [CW-1:0]    c [TAPS];
  logic signed [AW-1:0]    acc;
  logic [KW-1:0]           k;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    sum;
  logic                    accept;
  logic                    addr_ok;
  logic                    coef_wr;
  logic                    last;

  always_comb begin
    prod     = d[k] * c[k];
    prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
    sum      = acc + prod_ext;
    last     = (k == LAST_K);
    accept   = (state == IDLE) && bus.in_ready && bus.in_valid;
    addr_ok  = ({1'b0, bus.coef_addr} < TAPS_K);
    coef_wr  = bus.coef_we && addr_ok && (state == IDLE);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)        state_next = MAC;
      MAC:     if (last)          state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // in_ready is registered from the next state so in_valid never reaches it combinationally
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      k             <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.coef_err  <= 1'b0;
    end else begin
      state        <= state_next;
      bus.in_ready <= (state_next == IDLE);
      bus.coef_err <= bus.coef_we && !coef_wr;
      if (state == MAC && last)
        bus.out_valid <= 1'b1;
      else if (state == OUT && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (accept)
        k <= '0;
      else if (state == MAC)
        k <= k + 1'b1;
    end
  end

  // A coefficient written in the acceptance cycle is already visible to tap 0 onward
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
      acc          <= '0;
      bus.out_data <= '0;
    end else begin
      if (coef_wr)
        c[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        d[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++)
          d[i] <= d[i-1];
        acc <= '0;
      end else if (state == MAC) begin
        acc <= sum;
        if (last)
          bus.out_data <= sum;
      end
    end
  end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: impulse table, extremes, backpressure, coefficient
// write rules, mid-operation reset and randomized samples against a convolution model.
`timescale 1ns/1ps
module tb_fir_serial_mac;
  localparam int DW   = 12;
  localparam int CW   = 16;
  localparam int TAPS = 15;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  fir_serial_mac_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus ();
  fir_serial_mac #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int acc_cyc = 0;
  longint exp_y  = 0;
  longint last_y = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int     x;
    longint y;
  } vec_t;

  vec_t imp_tab [TAPS];
  int   imp_c   [TAPS] = '{0, -2, 2, 18, -8, -62, 6, 90, 6, -62, -8, 18, 2, -2, 0};

  // Reference: coefficient file and newest-first sample history
  int coef_m [TAPS];
  int hist   [TAPS];

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      coef_m[i] = 0;
      hist[i]   = 0;
    end
  endtask

  function automatic longint model_push(input int x);
    longint y;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    y = 0;
    for (int j = 0; j < TAPS; j++) y += longint'(coef_m[j]) * longint'(hist[j]);
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic write_coef(input int addr, input int data, input bit exp_err, input string tag);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 16'(data);
    tick();
    bus.coef_we = 1'b0;
    check({tag, "_coef_err"}, longint'(bus.coef_err), longint'(exp_err));
    if (!exp_err) coef_m[addr] = data;
  endtask

  task automatic start_sample(input int x);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'(x);
    tick();
    bus.in_valid = 1'b0;
    acc_cyc = cyc_cnt;
    exp_y   = model_push(x);
  endtask

  task automatic wait_result(input longint expv, input int hold, input string tag);
    int n   = 0;
    int bad = 0;
    longint held;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 0, 1);
      bus.out_ready = 1'b1;
      return;
    end
    check({tag, "_latency"}, longint'(cyc_cnt - acc_cyc), TAPS);
    check({tag, "_y"}, bus.out_data, expv);
    held   = bus.out_data;
    last_y = held;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    if (hold > 0) check({tag, "_hold_bad_cycles"}, bad, 0);
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_drain"}, longint'(bus.out_valid), 0);
  endtask

  task automatic run_impulse(input string tag);
    for (int i = 0; i < TAPS; i++) write_coef(i, imp_c[i], 1'b0, tag);
    for (int i = 0; i < TAPS; i++) begin
      start_sample(imp_tab[i].x);
      wait_result(imp_tab[i].y, 0, $sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    for (int i = 0; i < TAPS; i++) begin
      imp_tab[i].x = (i == 0) ? 1 : 0;
      imp_tab[i].y = imp_c[i];
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_coef_err",  longint'(bus.coef_err), 0);
    nreset = 1'b1;
    tick();
    check("idle_in_ready", longint'(bus.in_ready), 1);

    run_impulse("imp");

    for (int i = 0; i < TAPS; i++) write_coef(i, -32768, 1'b0, "ext_neg");
    for (int i = 0; i < TAPS; i++) begin
      start_sample(-2048);
      wait_result(exp_y, 0, "ext_neg");
    end
    check("ext_neg_final", last_y, 64'sd1006632960);
    for (int i = 0; i < TAPS; i++) write_coef(i, 32767, 1'b0, "ext_pos");
    for (int i = 0; i < TAPS; i++) begin
      start_sample(-2048);
      wait_result(exp_y, 0, "ext_pos");
    end
    check("ext_pos_final", last_y, -64'sd1006602240);

    // Pending sample offered throughout a 20-cycle stall must wait for the drain
    bus.out_ready = 1'b0;
    start_sample(777);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'(-5);
    wait_result(exp_y, 20, "bp");
    start_sample(-5);
    wait_result(exp_y, 0, "bp_next");

    start_sample(300);
    tick();
    tick();
    write_coef(3, 100, 1'b1, "busy");
    tick();
    check("busy_err_pulse_end", longint'(bus.coef_err), 0);
    wait_result(exp_y, 0, "busy");
    start_sample(-40);
    wait_result(exp_y, 0, "busy_next");
    write_coef(3, 100, 1'b0, "idle_wr");
    start_sample(9);
    wait_result(exp_y, 0, "idle_wr");

    write_coef(15, 1234, 1'b1, "oor");
    start_sample(11);
    wait_result(exp_y, 0, "oor");

    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 65535)) - 32768, 1'b0, "rnd_c");
    for (int s = 0; s < 25; s++) begin
      int hold;
      hold = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)) - 32768, 1'b0, "rnd_w");
      if (hold > 0) bus.out_ready = 1'b0;
      start_sample(int'($urandom_range(0, 4095)) - 2048);
      wait_result(exp_y, hold, $sformatf("rnd%0d", s));
    end

    start_sample(5);
    repeat (6) tick();
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(bus.out_valid), 0);
    check("mid_rst_out_data",  bus.out_data, 0);
    check("mid_rst_in_ready",  longint'(bus.in_ready), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    tick();
    check("post_rst_in_ready", longint'(bus.in_ready), 1);
    run_impulse("rst_imp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
